// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and fetches one word at a time from instruction memory.
// Fetched words go to the IF/ID register; a one-entry skid buffer absorbs stalls, and redirects squash in-flight fetches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iStall,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] oInstr,
  output logic [31:0] oNextPC,
  output logic        oValid
);

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]  state_r;
  logic [31:0] pc_r;
  logic [31:0] fpc_r;
  logic        discard_r;
  logic        skid_valid_r;
  logic [31:0] skid_instr_r;
  logic [31:0] skid_npc_r;
  logic        out_valid_r;
  logic [31:0] out_instr_r;
  logic [31:0] out_npc_r;

  logic        accept_s;
  logic        load_s;
  logic        consume_s;
  logic [31:0] fetched_npc_s;

  // A full skid buffer holds off new requests so a response always has somewhere to land.
  assign imem_req      = !reset && (state_r == ST_REQ) && !skid_valid_r;
  assign imem_addr     = pc_r;
  assign accept_s      = imem_req && imem_ready;
  assign load_s        = (state_r == ST_WAIT) && imem_rvalid && !discard_r;
  assign consume_s     = out_valid_r && !iStall;
  assign fetched_npc_s = fpc_r + 32'd4;

  assign oInstr  = out_instr_r;
  assign oNextPC = out_npc_r;
  assign oValid  = out_valid_r;

  // PC, request FSM, output register and skid buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_REQ;
      pc_r         <= RESET_PC;
      fpc_r        <= 32'h0000_0000;
      discard_r    <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_instr_r <= 32'h0000_0000;
      skid_npc_r   <= 32'h0000_0000;
      out_valid_r  <= 1'b0;
      out_instr_r  <= 32'h0000_0000;
      out_npc_r    <= 32'h0000_0000;
    end else if (iRedirect) begin
      pc_r         <= iRedirectPC;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      if (state_r == ST_WAIT) begin
        // A response arriving with the redirect is dropped and closes the outstanding fetch.
        if (imem_rvalid) begin
          state_r   <= ST_REQ;
          discard_r <= 1'b0;
        end else begin
          state_r   <= ST_WAIT;
          discard_r <= 1'b1;
        end
      end else if (accept_s) begin
        fpc_r     <= pc_r;
        state_r   <= ST_WAIT;
        discard_r <= 1'b1;
      end else begin
        state_r <= ST_REQ;
      end
    end else begin
      case (state_r)
        ST_REQ: begin
          if (accept_s) begin
            fpc_r   <= pc_r;
            pc_r    <= pc_r + 32'd4;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            state_r   <= ST_REQ;
            discard_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_REQ;
        end
      endcase

      // Skid full implies no fetch outstanding, so draining it never collides with a load.
      if (consume_s && skid_valid_r) begin
        out_instr_r  <= skid_instr_r;
        out_npc_r    <= skid_npc_r;
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (load_s && (!out_valid_r || consume_s)) begin
        out_instr_r <= imem_rdata;
        out_npc_r   <= fetched_npc_s;
        out_valid_r <= 1'b1;
      end else if (load_s) begin
        skid_instr_r <= imem_rdata;
        skid_npc_r   <= fetched_npc_s;
        skid_valid_r <= 1'b1;
      end else if (consume_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against an in-order instruction-stream model driven by a behavioural memory.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        iStall;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] oInstr;
  logic [31:0] oNextPC;
  logic        oValid;

  int passes = 0;
  int total  = 0;

  // memory model state
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;
  int          mem_lat = 0;
  bit          force_en = 1'b0;
  logic [31:0] force_val = 32'h0;
  bit          acc;
  logic [31:0] acc_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .iStall(iStall), .iRedirect(iRedirect),
    .iRedirectPC(iRedirectPC), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .oInstr(oInstr), .oNextPC(oNextPC), .oValid(oValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h2008_0005;
  endfunction

  // One clock: drive the memory response, note acceptance, advance to the next negedge.
  task automatic step();
    imem_rvalid = pend && (pend_cnt == 0);
    imem_rdata  = imem_rvalid ? (force_en ? force_val : mem_word(pend_addr)) : $urandom();
    #1;
    acc      = imem_req && imem_ready;
    acc_addr = imem_addr;
    @(posedge clk);
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (imem_rvalid) pend = 1'b0;
      else if (pend && pend_cnt > 0) pend_cnt--;
      if (acc) begin
        pend      = 1'b1;
        pend_cnt  = mem_lat;
        pend_addr = acc_addr;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; iStall = 1'b0; iRedirect = 1'b0; iRedirectPC = 32'h0;
    imem_ready = 1'b1; mem_lat = 0; force_en = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; iStall = 1'b0; iRedirect = 1'b0; iRedirectPC = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    #1;
    total++;
    if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else passes++;
    step(); step();
    reset = 1'b0;
    #1;
    total++;
    if ({oValid, oInstr, oNextPC} !== {1'b0, 32'h0, 32'h0})
      $display("FAIL reset_out: got v=%b i=%h n=%h want 0/0/0", oValid, oInstr, oNextPC);
    else passes++;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0})
      $display("FAIL reset_first_req: got req=%b addr=%h want 1/00000000", imem_req, imem_addr);
    else passes++;
  endtask

  task automatic test_basic_fetch();
    do_reset();
    step();   // accept at 0
    total++;
    if (imem_req !== 1'b0) $display("FAIL basic_wait_req: got %b want 0", imem_req); else passes++;
    step();   // rvalid
    total++;
    if ({oValid, oInstr, oNextPC} !== {1'b1, 32'h2008_0005, 32'h4})
      $display("FAIL basic_out: got v=%b i=%h n=%h want 1/20080005/00000004", oValid, oInstr, oNextPC);
    else passes++;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h4})
      $display("FAIL basic_second_req: got req=%b addr=%h want 1/00000004", imem_req, imem_addr);
    else passes++;
  endtask

  task automatic test_ready_hold();
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0})
        $display("FAIL hold_req_%0d: got req=%b addr=%h want 1/00000000", i, imem_req, imem_addr);
      else passes++;
      step();
    end
    imem_ready = 1'b1;
    step();
    total++;
    if ({imem_req, imem_addr, pend} !== {1'b0, 32'h4, 1'b1})
      $display("FAIL hold_accept: got req=%b addr=%h pend=%b want 0/00000004/1", imem_req, imem_addr, pend);
    else passes++;
  endtask

  task automatic test_stall_skid();
    do_reset();
    step(); step();          // A presented
    iStall = 1'b1;
    step(); step();          // B accepted, B returns into skid
    total++;
    if ({oValid, oInstr, oNextPC, imem_req} !== {1'b1, mem_word(32'h0), 32'h4, 1'b0})
      $display("FAIL skid_hold: got v=%b i=%h n=%h req=%b want 1/%h/00000004/0",
               oValid, oInstr, oNextPC, imem_req, mem_word(32'h0));
    else passes++;
    iStall = 1'b0;
    step();
    total++;
    if ({oValid, oInstr, oNextPC} !== {1'b1, mem_word(32'h4), 32'h8})
      $display("FAIL skid_drain: got v=%b i=%h n=%h want 1/%h/00000008", oValid, oInstr, oNextPC, mem_word(32'h4));
    else passes++;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h8})
      $display("FAIL skid_next_req: got req=%b addr=%h want 1/00000008", imem_req, imem_addr);
    else passes++;
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_lat = 1;
    step();                  // accept at 0, response two cycles later
    iRedirect = 1'b1; iRedirectPC = 32'h0000_0100;
    step();
    iRedirect = 1'b0;
    total++;
    if (oValid !== 1'b0) $display("FAIL redir_wait_valid: got %b want 0", oValid); else passes++;
    force_en = 1'b1; force_val = 32'hDEAD_BEEF;
    step();                  // stale response dropped
    force_en = 1'b0; mem_lat = 0;
    total++;
    if ({oValid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h100} || oInstr === 32'hDEAD_BEEF)
      $display("FAIL redir_wait_drop: got v=%b i=%h req=%b addr=%h want 0/not deadbeef/1/00000100",
               oValid, oInstr, imem_req, imem_addr);
    else passes++;
    step(); step();
    total++;
    if ({oValid, oInstr, oNextPC} !== {1'b1, mem_word(32'h100), 32'h104})
      $display("FAIL redir_wait_target: got v=%b i=%h n=%h want 1/%h/00000104", oValid, oInstr, oNextPC, mem_word(32'h100));
    else passes++;
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    step();                  // accept at 0
    iRedirect = 1'b1; iRedirectPC = 32'h0000_0200;
    step();                  // rvalid in the redirect cycle
    iRedirect = 1'b0;
    total++;
    if ({oValid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200})
      $display("FAIL redir_rv: got v=%b req=%b addr=%h want 0/1/00000200", oValid, imem_req, imem_addr);
    else passes++;
    step(); step();
    total++;
    if ({oValid, oInstr, oNextPC} !== {1'b1, mem_word(32'h200), 32'h204})
      $display("FAIL redir_rv_target: got v=%b i=%h n=%h want 1/%h/00000204", oValid, oInstr, oNextPC, mem_word(32'h200));
    else passes++;
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ready = 1'b0;
    iRedirect = 1'b1; iRedirectPC = 32'hFFFF_FFFC;
    step();
    iRedirect = 1'b0; imem_ready = 1'b1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC})
      $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffc", imem_req, imem_addr);
    else passes++;
    step(); step();
    total++;
    if ({oValid, oInstr, oNextPC, imem_addr} !== {1'b1, mem_word(32'hFFFF_FFFC), 32'h0, 32'h0})
      $display("FAIL wrap_out: got v=%b i=%h n=%h addr=%h want 1/%h/00000000/00000000",
               oValid, oInstr, oNextPC, imem_addr, mem_word(32'hFFFF_FFFC));
    else passes++;
  endtask

  // Randomized run: consumed instructions must follow the architectural PC sequence.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic [31:0] held_addr;
    bit          held;
    int          idle;
    int          idle_max;
    int          errs;
    do_reset();
    exp_pc = 32'h0; held = 1'b0; idle = 0; idle_max = 0; errs = 0;
    for (int c = 0; c < 4000; c++) begin
      iStall     = ($urandom_range(0, 99) < 30);
      imem_ready = ($urandom_range(0, 99) < 70);
      mem_lat    = $urandom_range(0, 2);
      iRedirect  = ($urandom_range(0, 99) < 3);
      tgt = $urandom();
      tgt[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0;
      iRedirectPC = tgt;
      if (held && errs < 10) begin
        total++;
        if ({imem_req, imem_addr} !== {1'b1, held_addr}) begin
          $display("FAIL rand_req_stable c=%0d: got req=%b addr=%h want 1/%h", c, imem_req, imem_addr, held_addr);
          errs++;
        end else passes++;
      end
      if (oValid && !iStall) begin
        total++;
        if ({oInstr, oNextPC} !== {mem_word(exp_pc), exp_pc + 32'd4}) begin
          if (errs < 10)
            $display("FAIL rand_stream c=%0d: got i=%h n=%h want %h/%h", c, oInstr, oNextPC, mem_word(exp_pc), exp_pc + 32'd4);
          errs++;
        end else passes++;
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end else begin
        idle++;
        if (idle > idle_max) idle_max = idle;
      end
      if (iRedirect) exp_pc = iRedirectPC;
      held      = imem_req && !imem_ready && !iRedirect;
      held_addr = imem_addr;
      step();
    end
    total++;
    if (idle_max > 60) $display("FAIL rand_progress: got max idle %0d want <= 60", idle_max);
    else passes++;
    iStall = 1'b0; iRedirect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_ready_hold();
    test_stall_skid();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
